// File: rtl/bsnn_ttfs_neuron.sv
//==============================================================================
// Module      : bsnn_ttfs_neuron
// Description : Binary-weight integrate-and-fire neuron with time-to-first-spike
//               output; integrates one coding window and reports firing time.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module bsnn_ttfs_neuron #(
    parameter int N_IN      = 16,
    parameter int DTT_WIDTH = 5,
    parameter int POT_WIDTH = 8
) (
    input  logic                        CLK,
    input  logic                        nRES,
    input  logic                        start,
    input  logic [N_IN-1:0]             weights,
    input  logic signed [POT_WIDTH-1:0] threshold,
    input  logic [N_IN-1:0]             spikes_in,
    output logic                        busy,
    output logic                        spike_out,
    output logic                        done,
    output logic                        fire_valid,
    output logic [DTT_WIDTH-1:0]        fire_time
);

    localparam int CNT_W = $clog2(N_IN + 1);
    localparam int SUM_W = CNT_W + 1;
    localparam int EXT_W = ((POT_WIDTH > SUM_W) ? POT_WIDTH : SUM_W) + 1;
    localparam logic [DTT_WIDTH-1:0]   T_MAX   = {DTT_WIDTH{1'b1}};
    localparam logic signed [EXT_W-1:0] POT_MAX = EXT_W'((64'sd1 <<< (POT_WIDTH - 1)) - 64'sd1);
    localparam logic signed [EXT_W-1:0] POT_MIN = EXT_W'(-(64'sd1 <<< (POT_WIDTH - 1)));

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_INTEGRATE = 2'd1,
        S_DONE      = 2'd2
    } state_t;

    state_t                      state_q,      state_d;
    logic [N_IN-1:0]             weights_q,    weights_d;
    logic signed [POT_WIDTH-1:0] threshold_q,  threshold_d;
    logic signed [POT_WIDTH-1:0] potential_q,  potential_d;
    logic [DTT_WIDTH-1:0]        t_q,          t_d;
    logic                        fired_q,      fired_d;
    logic                        spike_q,      spike_d;
    logic                        fire_valid_q, fire_valid_d;
    logic [DTT_WIDTH-1:0]        fire_time_q,  fire_time_d;

    logic [CNT_W-1:0]            pos_cnt;
    logic [CNT_W-1:0]            neg_cnt;
    logic signed [EXT_W-1:0]     sum_ext;
    logic signed [EXT_W-1:0]     raw_ext;
    logic signed [POT_WIDTH-1:0] pot_next;

    // Excitatory and inhibitory spike counts under the latched weights.
    always_comb begin
        pos_cnt = '0;
        neg_cnt = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (spikes_in[i]) begin
                if (weights_q[i]) pos_cnt = pos_cnt + CNT_W'(1);
                else              neg_cnt = neg_cnt + CNT_W'(1);
            end
        end
    end

    // Add in a wider domain, then clamp back to the potential range.
    always_comb begin
        sum_ext = $signed(EXT_W'(pos_cnt)) - $signed(EXT_W'(neg_cnt));
        raw_ext = EXT_W'(potential_q) + sum_ext;
        if (raw_ext > POT_MAX)      pot_next = POT_MAX[POT_WIDTH-1:0];
        else if (raw_ext < POT_MIN) pot_next = POT_MIN[POT_WIDTH-1:0];
        else                        pot_next = raw_ext[POT_WIDTH-1:0];
    end

    always_comb begin
        state_d      = state_q;
        weights_d    = weights_q;
        threshold_d  = threshold_q;
        potential_d  = potential_q;
        t_d          = t_q;
        fired_d      = fired_q;
        spike_d      = 1'b0;
        fire_valid_d = fire_valid_q;
        fire_time_d  = fire_time_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    weights_d    = weights;
                    threshold_d  = threshold;
                    potential_d  = '0;
                    fired_d      = 1'b0;
                    fire_valid_d = 1'b0;
                    fire_time_d  = '0;
                    t_d          = DTT_WIDTH'(1);
                    state_d      = S_INTEGRATE;
                end
            end
            S_INTEGRATE: begin
                potential_d = pot_next;
                if (!fired_q && (pot_next >= threshold_q)) begin
                    fired_d     = 1'b1;
                    spike_d     = 1'b1;
                    fire_time_d = t_q;
                end
                // Fire rule for the last cycle is applied before leaving.
                if (t_q == T_MAX) begin
                    fire_valid_d = fired_d;
                    state_d      = S_DONE;
                end else begin
                    t_d = t_q + DTT_WIDTH'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nRES) begin
        if (!nRES) begin
            state_q      <= S_IDLE;
            weights_q    <= '0;
            threshold_q  <= '0;
            potential_q  <= '0;
            t_q          <= '0;
            fired_q      <= 1'b0;
            spike_q      <= 1'b0;
            fire_valid_q <= 1'b0;
            fire_time_q  <= '0;
        end else begin
            state_q      <= state_d;
            weights_q    <= weights_d;
            threshold_q  <= threshold_d;
            potential_q  <= potential_d;
            t_q          <= t_d;
            fired_q      <= fired_d;
            spike_q      <= spike_d;
            fire_valid_q <= fire_valid_d;
            fire_time_q  <= fire_time_d;
        end
    end

    assign busy       = (state_q == S_INTEGRATE);
    assign done       = (state_q == S_DONE);
    assign spike_out  = spike_q;
    assign fire_valid = fire_valid_q;
    assign fire_time  = fire_time_q;

endmodule

`default_nettype wire
